// File: rtl/tag_lookup_table_sa_pkg.sv
// Shared cache package: width helpers, default geometry and lookup FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package tag_lookup_table_sa_pkg;

  // Lookup FSM: normal operation or sequenced invalidate-all
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Default cache geometry: 26-bit word space, 128 blocks of 16 words, 4-way
  localparam int unsigned DEF_BW_ADDR_SPACE        = 26;
  localparam int unsigned DEF_CACHE_BLOCK_CAPACITY = 128;
  localparam int unsigned DEF_WORDS_PER_BLOCK      = 16;
  localparam int unsigned DEF_CACHE_ASSOCIATIVITY  = 4;

  function automatic int unsigned calc_bw_set(input int unsigned capacity, input int unsigned assoc);
    return `CLOG2(capacity / assoc);
  endfunction

  function automatic int unsigned calc_bw_tag(input int unsigned addr_space, input int unsigned words,
                                              input int unsigned capacity, input int unsigned assoc);
    return (addr_space - `CLOG2(words)) - calc_bw_set(capacity, assoc);
  endfunction

  // Derived widths of the default geometry
  localparam int unsigned BW_SET        = calc_bw_set(DEF_CACHE_BLOCK_CAPACITY, DEF_CACHE_ASSOCIATIVITY);
  localparam int unsigned BW_WAY        = `CLOG2(DEF_CACHE_ASSOCIATIVITY);
  localparam int unsigned BW_CACHE_ADDR = `CLOG2(DEF_CACHE_BLOCK_CAPACITY);
  localparam int unsigned BW_TAG        = calc_bw_tag(DEF_BW_ADDR_SPACE, DEF_WORDS_PER_BLOCK,
                                                      DEF_CACHE_BLOCK_CAPACITY, DEF_CACHE_ASSOCIATIVITY);

endpackage

// File: rtl/identity_comparator.sv
// Equality comparator between two equal-width operands.
// Latency: combinational.
// Backpressure: none.
module identity_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/tag_lookup_table_sa_way_priority_encoder.sv
// Priority encoder over a per-way bit vector, lowest- or highest-index first.
// Latency: combinational; returns index 0 with any_o low when no bit is set.
// Backpressure: none.
module way_priority_encoder #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned BW_IDX       = 2,
  parameter bit          LOWEST_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0]  vec_i,
  output logic [BW_IDX-1:0] idx_o,
  output logic              any_o
);

  // Scan in the order that lets the preferred end overwrite the others last
  always_comb begin
    idx_o = '0;
    if (LOWEST_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = BW_IDX'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec_i[i]) idx_o = BW_IDX'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/tag_lookup_table_sa.sv
// Set-associative tag table: registered hit/free lookup, tag write/remove, sequenced flush.
// Latency: lookup result 1 cycle after request; flush takes one cycle per set.
// Backpressure: busy_o high during flush; requests, writes and removes are dropped then.
module tag_lookup_table_sa
  import tag_lookup_table_sa_pkg::*;
#(
  parameter  int unsigned BW_ADDR_SPACE        = DEF_BW_ADDR_SPACE,
  parameter  int unsigned CACHE_BLOCK_CAPACITY = DEF_CACHE_BLOCK_CAPACITY,
  parameter  int unsigned WORDS_PER_BLOCK      = DEF_WORDS_PER_BLOCK,
  parameter  int unsigned CACHE_ASSOCIATIVITY  = DEF_CACHE_ASSOCIATIVITY,
  localparam int unsigned BW_WORDS_PER_BLOCK   = `CLOG2(WORDS_PER_BLOCK),
  localparam int unsigned BW_WAY               = `CLOG2(CACHE_ASSOCIATIVITY),
  localparam int unsigned BW_SET               = calc_bw_set(CACHE_BLOCK_CAPACITY, CACHE_ASSOCIATIVITY),
  localparam int unsigned BW_CACHE_ADDR        = `CLOG2(CACHE_BLOCK_CAPACITY),
  localparam int unsigned BW_BLOCK             = BW_ADDR_SPACE - BW_WORDS_PER_BLOCK,
  localparam int unsigned BW_TAG               = BW_BLOCK - BW_SET
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     req_i,
  input  logic [BW_BLOCK-1:0]      block_search_i,
  input  logic                     wren_i,
  input  logic                     rmen_i,
  input  logic [BW_CACHE_ADDR-1:0] addr_i,
  input  logic [BW_TAG-1:0]        tag_write_i,
  input  logic                     flush_i,
  output logic [BW_TAG-1:0]        tag_o,
  output logic                     valid_o,
  output logic                     hit_o,
  output logic [BW_CACHE_ADDR-1:0] addr_o,
  output logic                     free_o,
  output logic [BW_CACHE_ADDR-1:0] free_addr_o,
  output logic                     busy_o
);

  localparam int unsigned NUM_SETS = CACHE_BLOCK_CAPACITY / CACHE_ASSOCIATIVITY;
  // Set and way indices keep at least one bit so the one-set / one-way cases elaborate
  localparam int unsigned W_SET = (BW_SET > 0) ? BW_SET : 1;
  localparam int unsigned W_WAY = (BW_WAY > 0) ? BW_WAY : 1;
  localparam logic [W_SET-1:0] LAST_SET = W_SET'(NUM_SETS - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic                     w_idle;

  logic [BW_TAG-1:0]        r_tag_mem [CACHE_BLOCK_CAPACITY];
  logic [CACHE_BLOCK_CAPACITY-1:0] r_valid;
  logic [W_SET-1:0]         r_flush_set;

  logic                     r_valid_o;
  logic                     r_hit;
  logic [BW_CACHE_ADDR-1:0] r_addr;
  logic                     r_free;
  logic [BW_CACHE_ADDR-1:0] r_free_addr;

  logic [W_SET-1:0]         w_set;
  logic [BW_TAG-1:0]        w_tag;
  logic [BW_CACHE_ADDR-1:0] w_set_base;
  logic [BW_CACHE_ADDR-1:0] w_flush_base;

  logic [CACHE_ASSOCIATIVITY-1:0] w_match;
  logic [CACHE_ASSOCIATIVITY-1:0] w_hit_vec;
  logic [CACHE_ASSOCIATIVITY-1:0] w_free_vec;
  logic [W_WAY-1:0]         w_hit_way;
  logic [W_WAY-1:0]         w_free_way;
  logic                     w_hit;
  logic                     w_free;
  logic [BW_CACHE_ADDR-1:0] w_hit_addr;
  logic [BW_CACHE_ADDR-1:0] w_free_addr;

  // Split block address into set index (low bits) and tag; a single set has no index bits
  if (BW_SET > 0) begin : g_sets
    assign w_set = block_search_i[BW_SET-1:0];
    assign w_tag = block_search_i[BW_BLOCK-1:BW_SET];
  end else begin : g_one_set
    assign w_set = '0;
    assign w_tag = block_search_i;
  end

  // Entry index of way 0 in the looked-up set and in the set being flushed
  assign w_set_base   = BW_CACHE_ADDR'(w_set) << BW_WAY;
  assign w_flush_base = BW_CACHE_ADDR'(r_flush_set) << BW_WAY;

  for (genvar w = 0; w < CACHE_ASSOCIATIVITY; w++) begin : g_way
    logic [BW_CACHE_ADDR-1:0] w_entry;
    assign w_entry = w_set_base | BW_CACHE_ADDR'(w);

    identity_comparator #(
      .WIDTH (BW_TAG)
    ) u_cmp (
      .a_i  (r_tag_mem[w_entry]),
      .b_i  (w_tag),
      .eq_o (w_match[w])
    );

    assign w_hit_vec[w]  = w_match[w] & r_valid[w_entry];
    assign w_free_vec[w] = ~r_valid[w_entry];
  end

  // Duplicate valid matches should not exist; if they do, the highest way wins
  way_priority_encoder #(
    .WIDTH        (CACHE_ASSOCIATIVITY),
    .BW_IDX       (W_WAY),
    .LOWEST_FIRST (1'b0)
  ) u_hit_sel (
    .vec_i (w_hit_vec),
    .idx_o (w_hit_way),
    .any_o (w_hit)
  );

  // Miss handler fills the lowest invalid way first
  way_priority_encoder #(
    .WIDTH        (CACHE_ASSOCIATIVITY),
    .BW_IDX       (W_WAY),
    .LOWEST_FIRST (1'b1)
  ) u_free_sel (
    .vec_i (w_free_vec),
    .idx_o (w_free_way),
    .any_o (w_free)
  );

  // Encoders return way 0 when nothing is found, giving {set, 0} on miss / full set
  assign w_hit_addr  = w_set_base | BW_CACHE_ADDR'(w_hit_way);
  assign w_free_addr = w_set_base | BW_CACHE_ADDR'(w_free_way);

  // FSM state register
  always_ff @(posedge clock_i) begin
    if (!resetn_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state: flush walks every set once, then returns to idle
  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (flush_i) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_flush_set == LAST_SET) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tag/valid storage: write then remove so a simultaneous remove wins; flush clears a set per cycle
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_valid     <= '0;
      r_flush_set <= '0;
      for (int i = 0; i < CACHE_BLOCK_CAPACITY; i++) begin
        r_tag_mem[i] <= '0;
      end
    end else if (w_idle) begin
      if (wren_i) begin
        r_tag_mem[addr_i] <= tag_write_i;
        r_valid[addr_i]   <= 1'b1;
      end
      if (rmen_i) begin
        r_valid[addr_i] <= 1'b0;
      end
      r_flush_set <= '0;
    end else begin
      for (int w = 0; w < CACHE_ASSOCIATIVITY; w++) begin
        r_valid[w_flush_base | BW_CACHE_ADDR'(w)] <= 1'b0;
      end
      r_flush_set <= r_flush_set + W_SET'(1);
    end
  end

  // Lookup result register: compares against pre-edge storage, one-cycle pulse per request
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_valid_o   <= 1'b0;
      r_hit       <= 1'b0;
      r_free      <= 1'b0;
      r_addr      <= '0;
      r_free_addr <= '0;
    end else begin
      r_valid_o <= w_idle & req_i;
      r_hit     <= w_idle & req_i & w_hit;
      r_free    <= w_idle & req_i & w_free;
      if (w_idle && req_i) begin
        r_addr      <= w_hit_addr;
        r_free_addr <= w_free_addr;
      end
    end
  end

  assign tag_o       = r_tag_mem[addr_i];
  assign valid_o     = r_valid_o;
  assign hit_o       = r_hit;
  assign addr_o      = r_addr;
  assign free_o      = r_free;
  assign free_addr_o = r_free_addr;
  assign busy_o      = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_tag_lookup_table_sa.sv
// Bench for tag_lookup_table_sa: table-driven lookups plus flush and reset-mid-flush sequences.
// Lookup expectations are queued when a request is driven and checked one edge later.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_tag_lookup_table_sa;

  localparam int unsigned BW_BLK = 22;
  localparam int unsigned BW_TG  = 17;
  localparam int unsigned BW_CA  = 7;

  logic              clk;
  logic              resetn_i;
  logic              req_i;
  logic [BW_BLK-1:0] block_search_i;
  logic              wren_i;
  logic              rmen_i;
  logic [BW_CA-1:0]  addr_i;
  logic [BW_TG-1:0]  tag_write_i;
  logic              flush_i;
  logic [BW_TG-1:0]  tag_o;
  logic              valid_o;
  logic              hit_o;
  logic [BW_CA-1:0]  addr_o;
  logic              free_o;
  logic [BW_CA-1:0]  free_addr_o;
  logic              busy_o;

  typedef struct {
    logic              req;
    logic [BW_BLK-1:0] blk;
    logic              wren;
    logic              rmen;
    logic [BW_CA-1:0]  addr;
    logic [BW_TG-1:0]  tag;
    logic              chk_tag;
    logic [BW_TG-1:0]  e_tag;
    logic              e_hit;
    logic [BW_CA-1:0]  e_addr;
    logic              e_free;
    logic [BW_CA-1:0]  e_faddr;
  } vec_t;

  typedef struct packed {
    logic             hit;
    logic [BW_CA-1:0] addr;
    logic             free;
    logic [BW_CA-1:0] faddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl[16];

  tag_lookup_table_sa #(
    .BW_ADDR_SPACE        (26),
    .CACHE_BLOCK_CAPACITY (128),
    .WORDS_PER_BLOCK      (16),
    .CACHE_ASSOCIATIVITY  (4)
  ) dut (
    .clock_i        (clk),
    .resetn_i       (resetn_i),
    .req_i          (req_i),
    .block_search_i (block_search_i),
    .wren_i         (wren_i),
    .rmen_i         (rmen_i),
    .addr_i         (addr_i),
    .tag_write_i    (tag_write_i),
    .flush_i        (flush_i),
    .tag_o          (tag_o),
    .valid_o        (valid_o),
    .hit_o          (hit_o),
    .addr_o         (addr_o),
    .free_o         (free_o),
    .free_addr_o    (free_addr_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge, then pop/compare any result due after it
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid_o", {31'd0, valid_o}, 32'd1);
      check("hit_o", {31'd0, hit_o}, {31'd0, e.hit});
      check("addr_o", {25'd0, addr_o}, {25'd0, e.addr});
      check("free_o", {31'd0, free_o}, {31'd0, e.free});
      check("free_addr_o", {25'd0, free_addr_o}, {25'd0, e.faddr});
    end else begin
      check("valid_o_quiet", {31'd0, valid_o}, 32'd0);
    end
  endtask

  task automatic drive_idle();
    req_i          = 1'b0;
    block_search_i = '0;
    wren_i         = 1'b0;
    rmen_i         = 1'b0;
    addr_i         = '0;
    tag_write_i    = '0;
    flush_i        = 1'b0;
  endtask

  function automatic vec_t mk(input logic rq, input logic [BW_BLK-1:0] blk, input logic wr, input logic rm,
                              input logic [BW_CA-1:0] ad, input logic [BW_TG-1:0] tg,
                              input logic ct, input logic [BW_TG-1:0] et,
                              input logic eh, input logic [BW_CA-1:0] ea,
                              input logic ef, input logic [BW_CA-1:0] efa);
    vec_t v;
    v.req = rq; v.blk = blk; v.wren = wr; v.rmen = rm; v.addr = ad; v.tag = tg;
    v.chk_tag = ct; v.e_tag = et; v.e_hit = eh; v.e_addr = ea; v.e_free = ef; v.e_faddr = efa;
    return v;
  endfunction

  // Drive one cycle of stimulus, check tag_o before the edge, queue the lookup result
  task automatic apply(input vec_t v);
    exp_t e;
    req_i          = v.req;
    block_search_i = v.blk;
    wren_i         = v.wren;
    rmen_i         = v.rmen;
    addr_i         = v.addr;
    tag_write_i    = v.tag;
    flush_i        = 1'b0;
    #1;
    if (v.chk_tag) check("tag_o", {15'd0, tag_o}, {15'd0, v.e_tag});
    if (v.req) begin
      e.hit = v.e_hit; e.addr = v.e_addr; e.free = v.e_free; e.faddr = v.e_faddr;
      exp_q.push_back(e);
    end
    tick();
    drive_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_hit_o"}, {31'd0, hit_o}, 32'd0);
    check({tag, "_free_o"}, {31'd0, free_o}, 32'd0);
    check({tag, "_busy_o"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_addr_o"}, {25'd0, addr_o}, 32'd0);
    check({tag, "_free_addr_o"}, {25'd0, free_addr_o}, 32'd0);
  endtask

  initial begin
    int   n;
    exp_t e;

    // Block 0x0A5 = set 5 tag 5; set 5 spans cache addresses 0x14..0x17
    //             req blk        wr rm addr   tag      ct  e_tag     hit e_addr free e_faddr
    tbl[0]  = mk(1, 22'h0000A5, 0, 0, 7'h00, 17'h0,   0, 17'h0,     0, 7'h14, 1, 7'h14);
    tbl[1]  = mk(0, 22'h0,      1, 0, 7'h16, 17'h5,   0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[2]  = mk(1, 22'h0000A5, 0, 0, 7'h16, 17'h0,   1, 17'h5,     1, 7'h16, 1, 7'h14);
    tbl[3]  = mk(0, 22'h0,      1, 0, 7'h14, 17'h10,  0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[4]  = mk(0, 22'h0,      1, 0, 7'h15, 17'h11,  0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[5]  = mk(0, 22'h0,      1, 0, 7'h17, 17'h13,  0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[6]  = mk(1, 22'h000225, 0, 0, 7'h00, 17'h0,   0, 17'h0,     1, 7'h15, 0, 7'h14);
    tbl[7]  = mk(0, 22'h0,      0, 1, 7'h15, 17'h0,   0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[8]  = mk(1, 22'h000225, 0, 0, 7'h00, 17'h0,   0, 17'h0,     0, 7'h14, 1, 7'h15);
    tbl[9]  = mk(0, 22'h0,      1, 1, 7'h16, 17'h1F,  0, 17'h0,     0, 7'h00, 0, 7'h00);
    tbl[10] = mk(1, 22'h0003E5, 0, 0, 7'h16, 17'h0,   1, 17'h1F,    0, 7'h14, 1, 7'h15);
    tbl[11] = mk(1, 22'h000225, 1, 0, 7'h15, 17'h11,  1, 17'h11,    0, 7'h14, 1, 7'h15);
    tbl[12] = mk(1, 22'h000225, 0, 0, 7'h00, 17'h0,   0, 17'h0,     1, 7'h15, 1, 7'h16);
    tbl[13] = mk(1, 22'h3FFFFF, 0, 0, 7'h7F, 17'h0,   1, 17'h0,     0, 7'h7C, 1, 7'h7C);
    tbl[14] = mk(0, 22'h0,      1, 0, 7'h7F, 17'h1FFFF, 0, 17'h0,   0, 7'h00, 0, 7'h00);
    tbl[15] = mk(1, 22'h3FFFFF, 0, 0, 7'h7F, 17'h0,   1, 17'h1FFFF, 1, 7'h7F, 1, 7'h7C);

    drive_idle();
    resetn_i = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    addr_i = 7'h16;
    #1;
    check("reset_tag_o", {15'd0, tag_o}, 32'd0);
    resetn_i = 1'b1;
    drive_idle();

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
    end

    // Give set 0 a valid entry, then start a flush together with a lookup and a write
    apply(mk(0, 22'h0, 1, 0, 7'h00, 17'h22, 0, 17'h0, 0, 7'h00, 0, 7'h00));
    req_i = 1'b1; block_search_i = 22'h000225;
    wren_i = 1'b1; addr_i = 7'h01; tag_write_i = 17'h33; flush_i = 1'b1;
    e.hit = 1'b1; e.addr = 7'h15; e.free = 1'b1; e.faddr = 7'h16;
    exp_q.push_back(e);
    tick();

    // Keep hammering requests and writes while busy; none may produce a result or land
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      req_i = 1'b1; block_search_i = 22'h000225;
      wren_i = 1'b1; addr_i = 7'h02; tag_write_i = 17'h44; flush_i = 1'b1;
      n++;
      tick();
    end
    drive_idle();
    check("flush_busy_cycles", n, 32);

    // Everything misses after the flush; tags survive, the flush-time write did not land
    apply(mk(1, 22'h000225, 0, 0, 7'h15, 17'h0, 1, 17'h11, 0, 7'h14, 1, 7'h14));
    apply(mk(1, 22'h3FFFFF, 0, 0, 7'h01, 17'h0, 1, 17'h33, 0, 7'h7C, 1, 7'h7C));
    apply(mk(1, 22'h000440, 0, 0, 7'h02, 17'h0, 1, 17'h0,  0, 7'h00, 1, 7'h00));

    // Reset in the middle of a flush: set 20 is still valid at flush cycle 10
    apply(mk(0, 22'h0,      1, 0, 7'h50, 17'h10, 0, 17'h0,  0, 7'h00, 0, 7'h00));
    apply(mk(1, 22'h000214, 0, 0, 7'h50, 17'h0,  1, 17'h10, 1, 7'h50, 1, 7'h51));
    flush_i = 1'b1;
    tick();
    drive_idle();
    check("flush2_busy", {31'd0, busy_o}, 32'd1);
    repeat (9) tick();
    resetn_i = 1'b0;
    tick();
    check_reset_outputs("midflush_reset");
    resetn_i = 1'b1;
    tick();
    check("post_reset_busy", {31'd0, busy_o}, 32'd0);
    apply(mk(1, 22'h000214, 0, 0, 7'h50, 17'h0, 1, 17'h0, 0, 7'h50, 1, 7'h50));
    apply(mk(1, 22'h000225, 0, 0, 7'h15, 17'h0, 1, 17'h0, 0, 7'h14, 1, 7'h14));

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tag_lookup_table_sa.md
# tag_lookup_table_sa

Parametrised set-associative tag lookup table for the two-stage cache. It maps a block address to a cache location `{set, way}` through a registered one-cycle lookup. It also reports the lowest free way in the addressed set for the miss handler and runs a sequenced invalidate-all (flush). It sits between the cache front-end and the replacement policy; with `CACHE_ASSOCIATIVITY = CACHE_BLOCK_CAPACITY` it degenerates to a single fully-associative set.

## Interface
Parameters:
- `BW_ADDR_SPACE`, 0: word-address width.
- `CACHE_BLOCK_CAPACITY`, 0: total blocks; power of two.
- `WORDS_PER_BLOCK`, 0: words per block; power of two.
- `CACHE_ASSOCIATIVITY`, 0: ways per set; power of two, ≤ capacity.
- Derived:
  - `BW_WORDS_PER_BLOCK` = clog2(words).
  - `BW_WAY` = clog2(assoc).
  - `BW_SET` = clog2(capacity/assoc); 0 means one set.
  - `BW_CACHE_ADDR` = clog2(capacity).
  - `BW_BLOCK` = `BW_ADDR_SPACE` − `BW_WORDS_PER_BLOCK`.
  - `BW_TAG` = `BW_BLOCK` − `BW_SET`.

Ports:
- `clock_i` in 1: single clock; all state updates on the rising edge.
- `resetn_i` in 1: reset, synchronous, active-low.
- `req_i` in 1: lookup request.
- `block_search_i` in `BW_BLOCK`: block address; low `BW_SET` bits are the set index, high bits are the tag.
- `wren_i` in 1: write tag and mark the entry valid.
- `rmen_i` in 1: invalidate entry.
- `addr_i` in `BW_CACHE_ADDR`: `{set, way}` target for write, remove and `tag_o`.
- `tag_write_i` in `BW_TAG`: tag to write.
- `flush_i` in 1: start invalidate-all.
- `tag_o` out `BW_TAG`: combinational tag stored at `addr_i`.
- `valid_o` out 1: lookup result valid.
- `hit_o` out 1: lookup hit.
- `addr_o` out `BW_CACHE_ADDR`: `{set, hit way}` on hit, else `{set, 0}`.
- `free_o` out 1: the addressed set has an invalid way.
- `free_addr_o` out `BW_CACHE_ADDR`: `{set, lowest invalid way}`; `{set, 0}` if none.
- `busy_o` out 1: flush in progress.

## Operation
- Storage: `tag_mem[capacity]` of `BW_TAG` bits and `valid[capacity]` of 1 bit; entry index = `{set, way}`.
- Lookup, when `req_i` is high in IDLE:
  - Set index selects `ASSOCIATIVITY` entries, each compared against the tag in parallel.
  - `hit` = OR over ways of (match & valid).
  - On multiple valid matches, the highest way index wins; writers must not create duplicates.
  - `free_o` / `free_addr_o` come from a lowest-index search over invalid ways of the same set.
- Write/remove:
  - `wren_i` sets `tag_mem[addr_i]` and `valid[addr_i]`.
  - `rmen_i` clears `valid[addr_i]`.
  - Both high on the same `addr_i`: the remove wins, so the entry ends invalid with the tag written.
- FSM:
  - IDLE: `flush_i` → FLUSH, loads `flush_set` = 0, and asserts `busy_o` from the next cycle.
  - FLUSH: each cycle clears all `valid` bits of `flush_set`, then increments it. After clearing the last set (all ones) → IDLE.
  - In FLUSH, `req_i`, `wren_i`, `rmen_i` and `flush_i` are ignored and `valid_o` stays low.
  - `tag_mem` contents are not cleared by flush.
- Reset, including mid-flush:
  - State → IDLE.
  - All `valid` bits and `tag_mem` → 0.
  - `valid_o`, `hit_o`, `free_o`, `busy_o` → 0; `addr_o`, `free_addr_o` → 0.

## Timing
- Lookup latency is 1 cycle: request at edge N yields `valid_o` / `hit_o` / `addr_o` / `free_*` registered and valid after edge N+1, held for one cycle only.
- The lookup at edge N compares against state before that edge's write/remove: no same-cycle forwarding.
- A request in the cycle after a write sees the written entry.
- Back-to-back requests give one result per cycle.
- `tag_o` is combinational and reflects writes from the previous edge.
- Flush occupies exactly 2^`BW_SET` cycles of `busy_o`.
- `flush_i` high in the same cycle as `req_i` in IDLE: the lookup is performed (result emitted) and the flush starts.
- `flush_i` high in the same cycle as `wren_i` / `rmen_i` in IDLE: the write/remove is applied and the flush starts.

## Structure
- The shared cache package holds:
  - the `CLOG2` macro;
  - the derived-width localparams (`BW_SET`, `BW_WAY`, `BW_TAG`, `BW_CACHE_ADDR`);
  - the FSM state encodings `ST_IDLE` and `ST_FLUSH`.
- Per-way comparison reuses `identity_comparator`.
- One new sub-module: `way_priority_encoder`, parameterised lowest/highest-first, width `ASSOCIATIVITY`. It returns the way index and an any-bit flag, and is instantiated twice (hit select, free select).
- The `BW_SET` = 0 case must elaborate; set-index slices are guarded in generate blocks.

## Test plan
Configuration for all scenarios: `BW_ADDR_SPACE` = 26, capacity 128, 16 words per block, 4-way. This gives 32 sets, `BW_TAG` = 17.
- Reset, then req block 0x00A5 → `valid_o` = 1, `hit_o` = 0, `free_o` = 1, `free_addr_o` = 0x14 (set 5, way 0).
- Write tag 0x0005 at `addr_i` 0x16 (set 5, way 2); next cycle req block 0x00A5 → `hit_o` = 1, `addr_o` = 0x16; `tag_o` with `addr_i` = 0x16 reads 0x0005.
- Fill set 5 ways 0–3, remove way 1, req any set-5 block → `free_o` = 1, `free_addr_o` = 0x15. Before the remove → `free_o` = 0.
- `wren_i` and `rmen_i` both high at 0x16 → the following lookup misses and `tag_o` = the new tag.
- Same-cycle write and req of the same block → result `hit_o` = 0; a repeat req next cycle → `hit_o` = 1.
- Fill several sets, pulse `flush_i`:
  - `busy_o` is high exactly 32 cycles and requests during them produce no `valid_o`;
  - afterwards all lookups miss;
  - a repeat with reset asserted at flush cycle 10 → `busy_o` = 0 next cycle and all entries invalid.
